// File: rtl/button_reader.sv
// Debounced active-low push-button reader producing a clean level plus
// press / release / long-press / auto-repeat single-cycle strobes.
module button_reader #(
  parameter int TANG_NANO_HZ  = 24_000_000,
  parameter int DEBOUNCE_MS   = 10,
  parameter int LONG_PRESS_MS = 1000,
  parameter int REPEAT_MS     = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DEB_CYCLES  = TANG_NANO_HZ / 1000 * DEBOUNCE_MS;
  localparam int LONG_CYCLES = TANG_NANO_HZ / 1000 * LONG_PRESS_MS;
  localparam int REP_CYCLES  = TANG_NANO_HZ / 1000 * REPEAT_MS;
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int REP_W  = $clog2(REP_CYCLES + 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);

  generate
    if (DEB_CYCLES < 1 || REP_CYCLES < 1 || LONG_CYCLES <= DEB_CYCLES) begin : g_param_check
      $error("button_reader: derived cycle counts must be >= 1 and LONG_CYCLES > DEB_CYCLES");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRESS_WAIT, ST_HELD, ST_LONG, ST_RELEASE_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync2_q;
  logic [DEB_W-1:0]  deb_q, deb_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              was_long_q, was_long_d;
  logic              pressed_q, pressed_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              repeat_q, repeat_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= ST_IDLE;
      deb_q      <= {DEB_W{1'b0}};
      hold_q     <= {HOLD_W{1'b0}};
      rep_q      <= {REP_W{1'b0}};
      was_long_q <= 1'b0;
      pressed_q  <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync1_q    <= btn_n;
      sync2_q    <= sync1_q;
      state_q    <= state_d;
      deb_q      <= deb_d;
      hold_q     <= hold_d;
      rep_q      <= rep_d;
      was_long_q <= was_long_d;
      pressed_q  <= pressed_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    deb_d      = deb_q;
    hold_d     = hold_q;
    rep_d      = rep_q;
    was_long_d = was_long_q;
    pressed_d  = pressed_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!sync2_q) begin
          if (DEB_CYCLES == 1) begin
            state_d   = ST_HELD;
            press_d   = 1'b1;
            pressed_d = 1'b1;
            hold_d    = {HOLD_W{1'b0}};
          end else begin
            state_d = ST_PRESS_WAIT;
            deb_d   = DEB_W'(1);
          end
        end else begin
          deb_d = {DEB_W{1'b0}};
        end
      end
      ST_PRESS_WAIT: begin
        if (sync2_q) begin
          state_d = ST_IDLE;
          deb_d   = {DEB_W{1'b0}};
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_HELD;
          press_d   = 1'b1;
          pressed_d = 1'b1;
          hold_d    = {HOLD_W{1'b0}};
          deb_d     = {DEB_W{1'b0}};
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      ST_HELD, ST_LONG: begin
        if (sync2_q) begin
          // A release sample counts as the first stable-high sample.
          was_long_d = (state_q == ST_LONG);
          if (DEB_CYCLES == 1) begin
            state_d   = ST_IDLE;
            release_d = 1'b1;
            pressed_d = 1'b0;
          end else begin
            state_d = ST_RELEASE_WAIT;
            deb_d   = DEB_W'(1);
          end
        end else if (state_q == ST_HELD) begin
          hold_d = hold_q + HOLD_W'(1);
          if (hold_q == HOLD_LAST) begin
            state_d = ST_LONG;
            long_d  = 1'b1;
            rep_d   = {REP_W{1'b0}};
          end else begin
            state_d = ST_HELD;
          end
        end else if (rep_q == REP_LAST) begin
          repeat_d = 1'b1;
          rep_d    = {REP_W{1'b0}};
        end else begin
          rep_d = rep_q + REP_W'(1);
        end
      end
      ST_RELEASE_WAIT: begin
        if (!sync2_q) begin
          state_d = was_long_q ? ST_LONG : ST_HELD;
          deb_d   = {DEB_W{1'b0}};
        end else if (deb_q == DEB_LAST) begin
          state_d   = ST_IDLE;
          release_d = 1'b1;
          pressed_d = 1'b0;
          deb_d     = {DEB_W{1'b0}};
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader at 1 cycle/ms: a run-length behavioural
// model is compared every cycle, plus hand-computed strobe edge numbers.
module tb_button_reader;
  localparam int DEB = 4;
  localparam int LONG = 20;
  localparam int REP = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

  button_reader #(
    .TANG_NANO_HZ(1000), .DEBOUNCE_MS(DEB), .LONG_PRESS_MS(LONG), .REPEAT_MS(REP)
  ) dut (
    .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pressed),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_s1 = 1, m_s2 = 1, m_pressed = 0, m_run = 0, m_ticks = 0;
  int m_press = 0, m_rel = 0, m_long = 0, m_rep = 0;
  int press_edge = 0, rel_edge = 0, long_edge = 0, last_rep = 0;
  int press_cnt = 0, rel_cnt = 0, rep_cnt = 0;
  logic prev_press = 1'b0, prev_rel = 1'b0, prev_long = 1'b0, prev_rep = 1'b0;
  logic last_was_press = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: accepted level flips after DEB consecutive disagreeing samples;
  // effective hold time counts only low samples not interrupted by a bounce.
  always @(posedge clk) begin : model
    int samp;
    cyc = cyc + 1;
    m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
    if (rst) begin
      m_s1 = 1; m_s2 = 1; m_pressed = 0; m_run = 0; m_ticks = 0;
    end else begin
      samp = m_s2;
      m_s2 = m_s1;
      m_s1 = int'(btn_n);
      if (m_pressed == 0) begin
        m_run = (samp == 0) ? m_run + 1 : 0;
        if (m_run == DEB) begin
          m_pressed = 1; m_press = 1; m_run = 0; m_ticks = 0;
        end
      end else if (samp == 1) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_pressed = 0; m_rel = 1; m_run = 0;
        end
      end else begin
        if (m_run == 0) begin
          m_ticks = m_ticks + 1;
          if (m_ticks == LONG) m_long = 1;
          else if (m_ticks > LONG && (m_ticks - LONG) % REP == 0) m_rep = 1;
        end
        m_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    check("pressed", pressed, m_pressed);
    check("press_pulse", press_pulse, m_press);
    check("release_pulse", release_pulse, m_rel);
    check("long_pulse", long_pulse, m_long);
    check("repeat_pulse", repeat_pulse, m_rep);
    check("one_strobe", $countones({press_pulse, release_pulse, long_pulse, repeat_pulse}) <= 1, 1);
    check("strobe_width", (press_pulse & prev_press) | (release_pulse & prev_rel) |
                          (long_pulse & prev_long) | (repeat_pulse & prev_rep), 0);
    if (rst) last_was_press = 1'b0;
    if (press_pulse) begin
      check("alternate_press", last_was_press, 0);
      last_was_press = 1'b1; press_edge = cyc; press_cnt++;
    end
    if (release_pulse) begin
      check("alternate_release", last_was_press, 1);
      last_was_press = 1'b0; rel_edge = cyc; rel_cnt++;
    end
    if (long_pulse) long_edge = cyc;
    if (repeat_pulse) begin
      last_rep = cyc; rep_cnt++;
    end
    prev_press = press_pulse; prev_rel = release_pulse;
    prev_long = long_pulse; prev_rep = repeat_pulse;
  end

  // Return just after the negedge following edge e, i.e. before edge e+1.
  task automatic to_edge(input int e);
    while (cyc < e) @(negedge clk);
    #2;
  endtask

  initial begin
    int t0, pc, rc, relc;
    to_edge(2);
    check("rst_pressed", pressed, 0);
    check("rst_strobes", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    rst = 1'b0;

    // 1: clean press, release before relative edge 50
    to_edge(10); t0 = cyc; btn_n = 1'b0;
    to_edge(t0 + 49); btn_n = 1'b1;
    to_edge(t0 + 60);
    check("t1_press_edge", press_edge, t0 + 6);
    check("t1_long_edge", long_edge, t0 + 26);
    check("t1_release_edge", rel_edge, t0 + 55);
    check("t1_pressed_after", pressed, 0);

    // 2: bounce rejection
    pc = press_cnt;
    for (int i = 0; i < 5; i++) begin
      btn_n = 1'b0; to_edge(cyc + 3);
      btn_n = 1'b1; to_edge(cyc + 3);
    end
    to_edge(cyc + 6);
    check("t2_press_count", press_cnt, pc);
    check("t2_pressed", pressed, 0);

    // 3: long press and auto-repeat for 60 cycles
    t0 = cyc; rc = rep_cnt; btn_n = 1'b0;
    to_edge(t0 + 60); btn_n = 1'b1;
    to_edge(t0 + 75);
    check("t3_press_edge", press_edge, t0 + 6);
    check("t3_long_edge", long_edge, t0 + 26);
    check("t3_repeat_count", rep_cnt - rc, 7);
    check("t3_last_repeat", last_rep, t0 + 61);
    check("t3_release_edge", rel_edge, t0 + 66);

    // 4: release bounce at hold=10
    t0 = cyc; relc = rel_cnt; btn_n = 1'b0;
    to_edge(t0 + 14); btn_n = 1'b1;
    to_edge(t0 + 16); btn_n = 1'b0;
    to_edge(t0 + 35);
    check("t4_press_edge", press_edge, t0 + 6);
    check("t4_long_edge", long_edge, t0 + 29);
    check("t4_no_release", rel_cnt, relc);
    check("t4_pressed", pressed, 1);
    btn_n = 1'b1; to_edge(cyc + 10);
    check("t4_released", pressed, 0);

    // 5: reset while in long-press, button still held
    t0 = cyc; relc = rel_cnt; btn_n = 1'b0;
    to_edge(t0 + 30); rst = 1'b1;
    to_edge(t0 + 31); rst = 1'b0;
    check("t5_rst_pressed", pressed, 0);
    check("t5_rst_strobes", {press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
    to_edge(t0 + 40);
    check("t5_repress_edge", press_edge, t0 + 37);
    check("t5_no_release", rel_cnt, relc);
    btn_n = 1'b1; to_edge(cyc + 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
